// File: rtl/riscv_core_mul_seq_if.sv
// Handshake/data bundle between the execute stage and riscv_core_mul_seq.
// Signal names carry the block's i_/o_ direction as seen from the multiplier.
interface riscv_core_mul_seq_if #(
    parameter int XLEN = 32
);
    logic            i_mul_seq_valid;
    logic            o_mul_seq_ready;
    logic [XLEN-1:0] i_mul_seq_multiplicand;
    logic [XLEN-1:0] i_mul_seq_multiplier;
    logic [1:0]      i_mul_seq_control;
    logic            i_mul_seq_negate;
    logic            i_mul_seq_flush;
    logic            o_mul_seq_valid;
    logic            i_mul_seq_ready;
    logic [XLEN-1:0] o_mul_seq_result;
    logic            o_mul_seq_busy;

    modport slave (
        input  i_mul_seq_valid, i_mul_seq_multiplicand, i_mul_seq_multiplier,
        input  i_mul_seq_control, i_mul_seq_negate, i_mul_seq_flush, i_mul_seq_ready,
        output o_mul_seq_ready, o_mul_seq_valid, o_mul_seq_result, o_mul_seq_busy
    );

    modport master (
        output i_mul_seq_valid, i_mul_seq_multiplicand, i_mul_seq_multiplier,
        output i_mul_seq_control, i_mul_seq_negate, i_mul_seq_flush, i_mul_seq_ready,
        input  o_mul_seq_ready, o_mul_seq_valid, o_mul_seq_result, o_mul_seq_busy
    );
endinterface

// File: rtl/riscv_core_mul_seq.sv
// Iterative unsigned shift-add multiplier with result negate and half select.
// Define MUL_SEQ_RADIX4_EN for radix-4 stepping (XLEN/2 steps); default is radix-2.
module riscv_core_mul_seq #(
    parameter int XLEN = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    riscv_core_mul_seq_if.slave   mul_if
);
`ifdef MUL_SEQ_RADIX4_EN
    localparam int unsigned N = XLEN / 2;
`else
    localparam int unsigned N = XLEN;
`endif
    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [2*XLEN-1:0] ONE_2X = (2*XLEN)'(1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e            state_q;
    logic [2*XLEN-1:0] acc_q, acc_d, prod_d;
    logic [XLEN-1:0]   mcand_q, result_q, result_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic [1:0]        ctrl_q;
    logic              zero_op;
`ifdef MUL_SEQ_RADIX4_EN
    logic [XLEN+1:0]   m3_q, addend, sum;
`else
    logic [XLEN:0]     sum;
`endif

    always_comb begin
`ifdef MUL_SEQ_RADIX4_EN
        addend = '0;
        unique case (acc_q[1:0])
            2'b00: addend = '0;
            2'b01: addend = {2'b00, mcand_q};
            2'b10: addend = {1'b0, mcand_q, 1'b0};
            2'b11: addend = m3_q;
        endcase
        sum   = {2'b00, acc_q[2*XLEN-1:XLEN]} + addend;
        acc_d = {sum, acc_q[XLEN-1:2]};
`else
        sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d = {sum, acc_q[XLEN-1:1]};
`endif
        prod_d   = neg_q ? (~acc_q + ONE_2X) : acc_q;
        result_d = (ctrl_q == 2'b00) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
        zero_op  = (mul_if.i_mul_seq_multiplicand == '0) || (mul_if.i_mul_seq_multiplier == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            ctrl_q   <= 2'b00;
`ifdef MUL_SEQ_RADIX4_EN
            m3_q     <= '0;
`endif
        end else if (mul_if.i_mul_seq_flush) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (mul_if.i_mul_seq_valid) begin
                    mcand_q <= mul_if.i_mul_seq_multiplicand;
                    neg_q   <= mul_if.i_mul_seq_negate;
                    ctrl_q  <= mul_if.i_mul_seq_control;
                    acc_q   <= {{XLEN{1'b0}}, mul_if.i_mul_seq_multiplier};
                    cnt_q   <= CNT_W'(N - 1);
`ifdef MUL_SEQ_RADIX4_EN
                    m3_q    <= {2'b00, mul_if.i_mul_seq_multiplicand}
                             + {1'b0, mul_if.i_mul_seq_multiplicand, 1'b0};
`endif
                    // A zero operand makes the product zero regardless of negate.
                    if (zero_op) begin
                        result_q <= '0;
                        state_q  <= DONE;
                    end else begin
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    result_q <= result_d;
                    state_q  <= DONE;
                end
                DONE: if (mul_if.i_mul_seq_ready) state_q <= IDLE;
            endcase
        end
    end

    assign mul_if.o_mul_seq_ready  = (state_q == IDLE);
    assign mul_if.o_mul_seq_valid  = (state_q == DONE);
    assign mul_if.o_mul_seq_busy   = (state_q == CALC) || (state_q == FIX);
    assign mul_if.o_mul_seq_result = result_q;
endmodule

// File: tb/tb_riscv_core_mul_seq.sv
// Directed bench for riscv_core_mul_seq: products, latency, backpressure, flush, reset.
module tb_riscv_core_mul_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_core_mul_seq_if #(.XLEN(32)) bus ();
    riscv_core_mul_seq #(.XLEN(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .mul_if(bus));

`ifdef MUL_SEQ_RADIX4_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 34;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic neg);
        @(negedge clk);
        bus.i_mul_seq_valid        = 1'b1;
        bus.i_mul_seq_control      = ctrl;
        bus.i_mul_seq_multiplicand = a;
        bus.i_mul_seq_multiplier   = b;
        bus.i_mul_seq_negate       = neg;
        @(posedge clk);
        #1;
        bus.i_mul_seq_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input logic neg, input logic [31:0] exp_res,
                          input int exp_lat, output logic busy_seen);
        int lat;
        start(ctrl, a, b, neg);
        chk({tag, " ready after accept"}, 32'(bus.o_mul_seq_ready), 32'd0);
        busy_seen = bus.o_mul_seq_busy;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            busy_seen = busy_seen | bus.o_mul_seq_busy;
            if (bus.o_mul_seq_valid) break;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, bus.o_mul_seq_result, exp_res);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        bus.i_mul_seq_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_mul_seq_ready = 1'b0;
        chk({tag, " valid after hs"}, 32'(bus.o_mul_seq_valid), 32'd0);
        chk({tag, " ready after hs"}, 32'(bus.o_mul_seq_ready), 32'd1);
    endtask

    initial begin
        logic bs;
        logic seen;
        bus.i_mul_seq_valid        = 1'b0;
        bus.i_mul_seq_multiplicand = '0;
        bus.i_mul_seq_multiplier   = '0;
        bus.i_mul_seq_control      = 2'b00;
        bus.i_mul_seq_negate       = 1'b0;
        bus.i_mul_seq_flush        = 1'b0;
        bus.i_mul_seq_ready        = 1'b0;
        #1;
        chk("rst ready",  32'(bus.o_mul_seq_ready), 32'd1);
        chk("rst valid",  32'(bus.o_mul_seq_valid), 32'd0);
        chk("rst busy",   32'(bus.o_mul_seq_busy), 32'd0);
        chk("rst result", bus.o_mul_seq_result, 32'd0);
        #11 rst_n = 1'b1;

        // MUL with backpressure in DONE
        run_op("mul7x6", 2'b00, 32'd7, 32'd6, 1'b0, 32'h0000002A, LAT, bs);
        chk("mul7x6 busy seen", 32'(bs), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp valid", 32'(bus.o_mul_seq_valid), 32'd1);
            chk("bp result", bus.o_mul_seq_result, 32'h0000002A);
            chk("bp ready", 32'(bus.o_mul_seq_ready), 32'd0);
        end
        // Request presented during the DONE handshake must wait one cycle
        @(negedge clk);
        bus.i_mul_seq_ready        = 1'b1;
        bus.i_mul_seq_valid        = 1'b1;
        bus.i_mul_seq_control      = 2'b00;
        bus.i_mul_seq_multiplicand = 32'd5;
        bus.i_mul_seq_multiplier   = 32'd5;
        bus.i_mul_seq_negate       = 1'b0;
        @(posedge clk);
        #1;
        bus.i_mul_seq_ready = 1'b0;
        chk("turnaround valid", 32'(bus.o_mul_seq_valid), 32'd0);
        chk("turnaround ready", 32'(bus.o_mul_seq_ready), 32'd1);
        chk("turnaround busy", 32'(bus.o_mul_seq_busy), 32'd0);
        @(posedge clk);
        #1;
        bus.i_mul_seq_valid = 1'b0;
        chk("second accept busy", 32'(bus.o_mul_seq_busy), 32'd1);
        chk("second accept ready", 32'(bus.o_mul_seq_ready), 32'd0);

        // Flush on the 10th CALC cycle
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.i_mul_seq_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_mul_seq_flush = 1'b0;
        chk("flush ready", 32'(bus.o_mul_seq_ready), 32'd1);
        chk("flush busy", 32'(bus.o_mul_seq_busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | bus.o_mul_seq_valid;
        end
        chk("flush no valid", 32'(seen), 32'd0);

        run_op("mulh min", 2'b01, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, LAT, bs);
        handshake("mulh min");
        run_op("mulhu max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, LAT, bs);
        handshake("mulhu max");
        run_op("mul max lo", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, LAT, bs);
        handshake("mul max lo");
        run_op("mulh neg1", 2'b01, 32'd1, 32'd1, 1'b1, 32'hFFFFFFFF, LAT, bs);
        handshake("mulh neg1");
        run_op("mul neg1", 2'b00, 32'd1, 32'd1, 1'b1, 32'hFFFFFFFF, LAT, bs);
        handshake("mul neg1");
        run_op("mulhsu", 2'b10, 32'h12345678, 32'h00000010, 1'b0, 32'h00000001, LAT, bs);
        handshake("mulhsu");
        run_op("mulhu neg", 2'b11, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFF, LAT, bs);
        handshake("mulhu neg");

        // Zero shortcut
        run_op("zero a", 2'b00, 32'd0, 32'h00001234, 1'b1, 32'h00000000, 1, bs);
        chk("zero a busy never", 32'(bs), 32'd0);
        handshake("zero a");
        run_op("zero b", 2'b11, 32'h00000055, 32'd0, 1'b0, 32'h00000000, 1, bs);
        chk("zero b busy never", 32'(bs), 32'd0);
        handshake("zero b");

        // Flush dominates a request in IDLE
        @(negedge clk);
        bus.i_mul_seq_valid        = 1'b1;
        bus.i_mul_seq_flush        = 1'b1;
        bus.i_mul_seq_multiplicand = 32'd3;
        bus.i_mul_seq_multiplier   = 32'd4;
        @(posedge clk);
        #1;
        bus.i_mul_seq_valid = 1'b0;
        bus.i_mul_seq_flush = 1'b0;
        chk("flush idle ready", 32'(bus.o_mul_seq_ready), 32'd1);
        chk("flush idle busy", 32'(bus.o_mul_seq_busy), 32'd0);

        run_op("mul neg 15", 2'b00, 32'd3, 32'd5, 1'b1, 32'hFFFFFFF1, LAT, bs);
        handshake("mul neg 15");

        // Asynchronous reset in the middle of CALC
        start(2'b00, 32'd9, 32'd9, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst ready", 32'(bus.o_mul_seq_ready), 32'd1);
        chk("arst valid", 32'(bus.o_mul_seq_valid), 32'd0);
        chk("arst busy", 32'(bus.o_mul_seq_busy), 32'd0);
        chk("arst result", bus.o_mul_seq_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("post reset", 2'b00, 32'd3, 32'd4, 1'b0, 32'h0000000C, LAT, bs);
        handshake("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
